pixel_fifo_rgbout: RTL and testbench
====================================

# pixel_fifo_rgbout

Pixel buffer and output stage feeding the 720p display timing generator. It accepts 64-bit words from the PL DMA read engine, each word holding two XRGB pixels. It reports the buffered pixel count on `rd_fifo_cnt` so the timing generator can arm its data-enable gate. It pops one pixel for every active `enable_in` cycle and presents registered RGB together with sync and data-enable outputs that are delayed to match.

## Interface
- `DEPTH_LOG2`, default 12: FIFO depth is 2^DEPTH_LOG2 64-bit words. Legal range is 4..13.
- `clock`  in  1: single clock for the DMA side and the pixel side.
- `resetn`  in  1: asynchronous, active-low.
- `s_data`  in  64: two pixels per word. Pixel 0 is `[23:0]`, pixel 1 is `[55:32]`. Bits `[31:24]` and `[63:56]` are ignored.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the FIFO can accept a word.
- `flush`  in  1: synchronous clear of all buffered data.
- `enable_in`  in  1: pixel request from the timing generator.
- `hsync_in`, `vsync_in`  in  1 each: syncs from the timing generator.
- `rgb_out`  out  24: pixel output, `{R,G,B}` with 8 bits each.
- `de_out`, `hsync_out`, `vsync_out`  out  1 each: `enable_in`, `hsync_in` and `vsync_in` delayed by 1 cycle.
- `rd_fifo_cnt`  out  15: number of buffered pixels.
- `underflow`  out  1: sticky error flag.
- `clr_underflow`  in  1: clears `underflow`.

## Operation
Storage:
- Word memory with asynchronous read, 64 bits × 2^DEPTH_LOG2.
- `wr_ptr` and `rd_ptr` are each DEPTH_LOG2 bits wide and wrap naturally.
- `wcount` is DEPTH_LOG2+1 bits wide and runs from 0 to 2^DEPTH_LOG2.
- A 1-bit `half` selects the lane of the head word.

Write side:
- `s_ready = (wcount != 2^DEPTH_LOG2) && !flush`. It is combinational from registered state and `flush`.
- A write occurs when `s_valid && s_ready`. The word is stored at `wr_ptr` and `wr_ptr` increments.
- When the FIFO is full, `s_data` is held off by the handshake. No data is lost.

Read side:
- A pop request is `enable_in`, evaluated at each clock edge.
- If `rd_fifo_cnt != 0`:
  - With `half==0`, the next `rgb_out` is `mem[rd_ptr][23:0]` and `half` becomes 1.
  - With `half==1`, the next `rgb_out` is `mem[rd_ptr][55:32]`, `half` becomes 0, `rd_ptr` increments and `wcount` decrements.
- If `rd_fifo_cnt == 0`, this is an underflow:
  - the next `rgb_out` is `24'h000000`;
  - `underflow` is set;
  - pointers and `half` are unchanged.
- When `enable_in` is low, `rgb_out` is forced to 0 on the next cycle.

Count and flags:
- `rd_fifo_cnt = 2*wcount - half`. It is registered and updated on the same edge as the pointers.
- A write and a word-pop on the same edge leave `wcount` unchanged.
- A write while `wcount==0` is followed by a pop request on the next cycle. That request returns the new pixel 0 and is not an underflow.
- `underflow` priority: a set on the same edge as `clr_underflow` wins, so the flag stays 1.

Flush:
- On `flush`, `wr_ptr`, `rd_ptr`, `wcount` and `half` all go to 0 and `rd_fifo_cnt` goes to 0 on the next edge.
- Flush has priority over any write or pop on the same edge.
- The sync and `de` delay pipeline is not affected by flush.
- During a flush cycle, `rgb_out` follows the underflow rule if `enable_in` is high, but `underflow` is NOT set.

## Timing
- Reset values:
  - `rgb_out=0`, `de_out=0`, `hsync_out=0`, `vsync_out=0`
  - `rd_fifo_cnt=0`, `underflow=0`
  - internal pointers, `wcount` and `half` are 0
  - `s_ready` is 1 once `resetn` is high
- Latency from `enable_in` to `rgb_out`/`de_out` is 1 cycle. The `hsync`/`vsync` paths have the same 1-cycle delay, so all four outputs stay mutually aligned.
- Latency from a write to `rd_fifo_cnt` is 1 cycle, an increase of 2.
- Latency from a write to the earliest pop of that data is 1 cycle.
- Throughput:
  - write side: 1 word per cycle;
  - read side: 1 pixel per cycle.
  - Sustained streaming needs only 1 word every 2 cycles.
- An asynchronous reset in the middle of a frame clears everything immediately. Outputs stay at their reset values until the first edge after `resetn` is released.

## Configuration
- `PIXOUT_UFLOW_CNT_EN`
  - Defined:
    - adds output port `uflow_cnt [15:0]`;
    - it increments by 1 on every underflow pop and saturates at `16'hFFFF`;
    - it resets to 0 on `resetn` and is cleared by `clr_underflow`;
    - if an increment and a clear occur on the same edge, the result is 1.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then write 3 words with `s_data` pixels `0x111111/0x222222`, `0x333333/0x444444`, `0x555555/0x666666` → `rd_fifo_cnt` reads 2, 4, 6 on successive cycles.
- Hold `enable_in` for 6 cycles → `rgb_out` is `11..66` in order, each 1 cycle after its request.
- With `DEPTH_LOG2=4`, hold `s_valid` high for 20 cycles and no reads → exactly 16 words are accepted, `s_ready=0`, `rd_fifo_cnt=32`. Pop 2 pixels → `s_ready` returns to 1 on the next cycle.
- Empty FIFO, `enable_in` high for 1 cycle → `rgb_out=0`, `de_out=1`, `underflow=1` and it stays 1. Pulse `clr_underflow` → `underflow=0` one cycle later. With the macro defined, `uflow_cnt` goes 1 then 0.
- With 1 word buffered and `half=1`, apply a write and a pop on the same edge → `rd_fifo_cnt` goes from 1 to 2, with `wcount` unchanged and the new word at the head.
- Mid-line `flush` with 10 pixels buffered and `enable_in` high → `rd_fifo_cnt=0`, `rgb_out=0`, `underflow` stays 0, and `hsync_out`/`vsync_out` remain 1-cycle copies of their inputs.

Source files
------------

// File: rtl/pixel_fifo_rgbout.sv
// Two-pixel-per-word FIFO feeding the 720p timing generator, with registered RGB/DE/sync outputs.
// Optional PIXOUT_UFLOW_CNT_EN adds a saturating underflow event counter on uflow_cnt.
module pixel_fifo_rgbout #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        flush,
  input  logic        enable_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [14:0] rd_fifo_cnt,
  output logic        underflow,
`ifdef PIXOUT_UFLOW_CNT_EN
  output logic [15:0] uflow_cnt,
`endif
  input  logic        clr_underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 2;
  localparam logic [DEPTH_LOG2:0] FULL_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Only the two 24-bit pixel lanes are kept; the pad bytes never reach the output.
  logic [47:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   wcount_q, wcount_d;
  logic                  half_q, half_d;
  logic [14:0]           cnt_q, cnt_d;
  logic [CW-1:0]         cnt_wide;
  logic [23:0]           rgb_q, rgb_d;
  logic                  de_q, hs_q, vs_q;
  logic                  uf_q, uf_d;
  logic                  wr_en, have_pix, pix_pop, word_pop, uflow_evt;
  logic [47:0]           head_word;
  logic                  unused_pad;

  assign unused_pad = ^{s_data[63:56], s_data[31:24]};

  // Handshake: a word transfers on every edge where s_valid && s_ready; s_ready
  // depends only on registered occupancy and flush, never on s_valid.
  assign s_ready   = (wcount_q != FULL_WORDS) && !flush;
  assign wr_en     = s_valid && s_ready;
  assign have_pix  = (cnt_q != 15'd0);
  assign pix_pop   = enable_in && have_pix && !flush;
  assign word_pop  = pix_pop && half_q;
  assign uflow_evt = enable_in && !have_pix && !flush;
  assign head_word = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s_data[55:32], s_data[23:0]};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wcount_d = wcount_q;
    half_d   = half_q;
    rgb_d    = 24'h000000;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wcount_d = '0;
      half_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pix_pop) begin
        half_d = ~half_q;
        rgb_d  = half_q ? head_word[47:24] : head_word[23:0];
      end
      if (word_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, word_pop})
        2'b10:   wcount_d = wcount_q + 1'b1;
        2'b01:   wcount_d = wcount_q - 1'b1;
        default: wcount_d = wcount_q;
      endcase
    end
  end

  // Pixel count tracks the next-state pointers so it lands on the same edge.
  assign cnt_wide = {wcount_d, 1'b0} - {{(CW-1){1'b0}}, half_d};
  assign cnt_d    = 15'(cnt_wide);

  always_comb begin
    uf_d = uf_q;
    if (uflow_evt) begin
      uf_d = 1'b1;
    end else if (clr_underflow) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcount_q <= '0;
      half_q   <= 1'b0;
      cnt_q    <= 15'd0;
      rgb_q    <= 24'h000000;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcount_q <= wcount_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
      de_q     <= enable_in;
      hs_q     <= hsync_in;
      vs_q     <= vsync_in;
      uf_q     <= uf_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign de_out      = de_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign rd_fifo_cnt = cnt_q;
  assign underflow   = uf_q;

`ifdef PIXOUT_UFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // A clear coinciding with a new underflow leaves that one event counted.
  always_comb begin
    ucnt_d = ucnt_q;
    if (uflow_evt && clr_underflow) begin
      ucnt_d = 16'd1;
    end else if (clr_underflow) begin
      ucnt_d = 16'd0;
    end else if (uflow_evt && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign uflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_pixel_fifo_rgbout.sv
// Bench for pixel_fifo_rgbout (DEPTH_LOG2=4): directed vector table, full/reset sequences,
// then randomized traffic against a pixel-queue reference model.
module tb_pixel_fifo_rgbout;

  localparam logic [4:0] C_EN  = 5'b10000;
  localparam logic [4:0] C_FL  = 5'b01000;
  localparam logic [4:0] C_HS  = 5'b00100;
  localparam logic [4:0] C_VS  = 5'b00010;
  localparam logic [4:0] C_CLR = 5'b00001;
  localparam logic [2:0] D_DE  = 3'b100;
  localparam logic [2:0] D_HS  = 3'b010;
  localparam logic [2:0] D_VS  = 3'b001;
  localparam int         WORDS = 16;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        flush = 1'b0;
  logic        enable_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        clr_underflow = 1'b0;
  logic [23:0] rgb_out;
  logic        de_out, hsync_out, vsync_out;
  logic [14:0] rd_fifo_cnt;
  logic        underflow;
`ifdef PIXOUT_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
`endif

  always #5 clock = ~clock;

  pixel_fifo_rgbout #(.DEPTH_LOG2(4)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .flush         (flush),
    .enable_in     (enable_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .rgb_out       (rgb_out),
    .de_out        (de_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .rd_fifo_cnt   (rd_fifo_cnt),
    .underflow     (underflow),
`ifdef PIXOUT_UFLOW_CNT_EN
    .uflow_cnt     (uflow_cnt),
`endif
    .clr_underflow (clr_underflow)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic        sv;
    logic [63:0] data;
    logic [4:0]  ctl;
    logic [23:0] e_rgb;
    logic [2:0]  e_dhv;
    logic [14:0] e_cnt;
    logic        e_uf;
    logic        e_rdy;
    logic [15:0] e_ucnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] wd(input logic [23:0] p0, input logic [23:0] p1);
    return {8'hA5, p1, 8'h5A, p0};
  endfunction

  function automatic vec_t mk(input logic sv, input logic [63:0] d, input logic [4:0] ctl,
                              input logic [23:0] rgb, input logic [2:0] dhv, input int cnt,
                              input logic uf, input logic rdy, input logic [15:0] uc);
    vec_t v;
    v.sv = sv; v.data = d; v.ctl = ctl; v.e_rgb = rgb; v.e_dhv = dhv;
    v.e_cnt = 15'(cnt); v.e_uf = uf; v.e_rdy = rdy; v.e_ucnt = uc;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  logic        m_uf;
  logic [15:0] m_ucnt;
  logic [23:0] m_rgb;
  logic        m_rdy, m_set;
  int          acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic sv, input logic [63:0] d, input logic [4:0] ctl);
    s_valid       = sv;
    s_data        = d;
    enable_in     = ctl[4];
    flush         = ctl[3];
    hsync_in      = ctl[2];
    vsync_in      = ctl[1];
    clr_underflow = ctl[0];
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // ---- reset ----
    drive(1'b0, '0, C_HS | C_VS | C_EN);
    repeat (3) @(negedge clock);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_de", de_out, 0);
    chk("rst_hs", hsync_out, 0);
    chk("rst_vs", vsync_out, 0);
    chk("rst_cnt", rd_fifo_cnt, 0);
    chk("rst_uf", underflow, 0);
    drive(1'b0, '0, 5'b0);
    resetn = 1'b1;
    #1;
    chk("rst_ready", s_ready, 1);
    @(negedge clock);

    // ---- directed table ----
    tbl.push_back(mk(1, wd(24'h111111, 24'h222222), 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(1, wd(24'h333333, 24'h444444), 0, 0, 0, 4, 0, 1, 0));
    tbl.push_back(mk(1, wd(24'h555555, 24'h666666), 0, 0, 0, 6, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'h111111, D_DE, 5, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'h222222, D_DE, 4, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'h333333, D_DE, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'h444444, D_DE, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'h555555, D_DE, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'h666666, D_DE, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 0, D_DE, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, C_CLR, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_HS, 0, D_HS, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN | C_VS | C_CLR, 0, D_DE | D_VS, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, C_CLR, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, wd(24'hAAAAAA, 24'hBBBBBB), 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'hAAAAAA, D_DE, 1, 0, 1, 0));
    tbl.push_back(mk(1, wd(24'hCCCCCC, 24'hDDDDDD), C_EN, 24'hBBBBBB, D_DE, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'hCCCCCC, D_DE, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'hDDDDDD, D_DE, 0, 0, 1, 0));
    tbl.push_back(mk(1, wd(24'hEEEEEE, 24'hFFFFFF), 0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN, 24'hEEEEEE, D_DE, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, C_EN | C_HS | C_VS, 24'hFFFFFF, D_DE | D_HS | D_VS, 0, 0, 1, 0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1, wd(24'h0A0000 + 24'(2 * k), 24'h0A0001 + 24'(2 * k)), 0, 0, 0,
                       2 * (k + 1), 0, 1, 0));
    end
    tbl.push_back(mk(1, wd(24'h123456, 24'h654321), C_EN | C_FL | C_HS, 0, D_DE | D_HS, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, C_EN | C_VS, 0, D_DE | D_VS, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, C_CLR, 0, 0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].sv, tbl[i].data, tbl[i].ctl);
      step();
      chk($sformatf("v%0d_rgb", i), rgb_out, tbl[i].e_rgb);
      chk($sformatf("v%0d_dhv", i), {de_out, hsync_out, vsync_out}, tbl[i].e_dhv);
      chk($sformatf("v%0d_cnt", i), rd_fifo_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d_uf", i), underflow, tbl[i].e_uf);
      chk($sformatf("v%0d_rdy", i), s_ready, tbl[i].e_rdy);
`ifdef PIXOUT_UFLOW_CNT_EN
      chk($sformatf("v%0d_ucnt", i), uflow_cnt, tbl[i].e_ucnt);
`endif
    end
    drive(1'b0, '0, 5'b0);

    // ---- fill to full with backpressure ----
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, wd(24'h100000 + 24'(acc), 24'h200000 + 24'(acc)), 5'b0);
      #1;
      if (s_ready) acc++;
      step();
    end
    drive(1'b0, '0, 5'b0);
    #1;
    chk("full_accepted", acc, WORDS);
    chk("full_ready", s_ready, 0);
    chk("full_cnt", rd_fifo_cnt, 32);
    drive(1'b0, '0, C_EN);
    step();
    chk("pop1_rgb", rgb_out, 24'h100000);
    chk("pop1_cnt", rd_fifo_cnt, 31);
    chk("pop1_ready", s_ready, 0);
    step();
    chk("pop2_rgb", rgb_out, 24'h200000);
    chk("pop2_cnt", rd_fifo_cnt, 30);
    chk("pop2_ready", s_ready, 1);
    step();
    chk("pop3_rgb", rgb_out, 24'h100001);
    drive(1'b0, '0, C_EN | C_HS);
    step();
    chk("pop4_rgb", rgb_out, 24'h200001);
    chk("pop4_cnt", rd_fifo_cnt, 28);

    // ---- asynchronous reset mid-frame ----
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rgb", rgb_out, 0);
    chk("arst_dhv", {de_out, hsync_out, vsync_out}, 0);
    chk("arst_cnt", rd_fifo_cnt, 0);
    step();
    chk("arst_hold_rgb", rgb_out, 0);
    chk("arst_hold_de", de_out, 0);
    drive(1'b0, '0, 5'b0);
    resetn = 1'b1;
    #1;
    chk("arst_rel_ready", s_ready, 1);
    chk("arst_rel_cnt", rd_fifo_cnt, 0);
    @(negedge clock);

    // ---- randomized traffic vs pixel-queue model ----
    exp_q.delete();
    m_uf   = 1'b0;
    m_ucnt = 16'd0;
    for (int blk = 0; blk < 12; blk++) begin
      int sv_pct = $urandom_range(10, 90);
      int en_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        logic        r_sv, r_en, r_fl, r_hs, r_vs, r_clr;
        logic [63:0] r_d;
        r_sv  = ($urandom_range(0, 99) < sv_pct);
        r_en  = ($urandom_range(0, 99) < en_pct);
        r_fl  = ($urandom_range(0, 63) == 0);
        r_clr = ($urandom_range(0, 31) == 0);
        r_hs  = 1'($urandom_range(0, 1));
        r_vs  = 1'($urandom_range(0, 1));
        r_d   = {$urandom, $urandom};
        drive(r_sv, r_d, {r_en, r_fl, r_hs, r_vs, r_clr});
        #1;
        m_rdy = ((exp_q.size() + 1) / 2 != WORDS) && !r_fl;
        chk("rnd_ready", s_ready, m_rdy);
        m_set = 1'b0;
        m_rgb = 24'h000000;
        if (r_fl) begin
          exp_q.delete();
        end else begin
          if (r_en) begin
            if (exp_q.size() > 0) m_rgb = exp_q.pop_front();
            else m_set = 1'b1;
          end
          if (r_sv && m_rdy) begin
            exp_q.push_back(r_d[23:0]);
            exp_q.push_back(r_d[55:32]);
          end
        end
        if (m_set) m_uf = 1'b1;
        else if (r_clr) m_uf = 1'b0;
        if (m_set && r_clr) m_ucnt = 16'd1;
        else if (r_clr) m_ucnt = 16'd0;
        else if (m_set && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
        step();
        chk("rnd_rgb", rgb_out, m_rgb);
        chk("rnd_dhv", {de_out, hsync_out, vsync_out}, {r_en, r_hs, r_vs});
        chk("rnd_cnt", rd_fifo_cnt, exp_q.size());
        chk("rnd_uf", underflow, m_uf);
`ifdef PIXOUT_UFLOW_CNT_EN
        chk("rnd_ucnt", uflow_cnt, m_ucnt);
`endif
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
